// File: rtl/icache_sa_pkg.sv
// Shared definitions for the set-associative instruction cache:
// FSM state encoding, geometry helpers and default parameter values.
package icache_sa_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_SET_BITS  = 6;
  localparam int DEF_LINE_BITS = 2;
  localparam int DEF_WAYS      = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MISS_REQ = 3'd2,
    ST_REFILL   = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  // Number of 32-bit words held by one cache line.
  function automatic int line_words(input int line_bits);
    return 1 << line_bits;
  endfunction

  // Tag width left over once the byte, word-offset and set-index bits are removed.
  function automatic int tag_width(input int addr_w, input int set_bits, input int line_bits);
    return addr_w - set_bits - line_bits - 2;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: tag, data and valid storage with a
// combinational lookup port, a whole-line write port and a bulk valid clear.
// Tag and data arrays carry no reset; only the valid bits do.
module icache_way
  import icache_sa_pkg::*;
#(
  parameter int SET_BITS  = DEF_SET_BITS,
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int TAG_W     = tag_width(DEF_ADDR_W, DEF_SET_BITS, DEF_LINE_BITS)
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic [SET_BITS-1:0]                lk_index,
  input  logic [LINE_BITS-1:0]               lk_offset,
  input  logic [TAG_W-1:0]                   lk_tag,
  output logic                               lk_valid,
  output logic                               lk_hit,
  output logic [31:0]                        lk_word,
  input  logic                               wr_en,
  input  logic [SET_BITS-1:0]                wr_index,
  input  logic [TAG_W-1:0]                   wr_tag,
  input  logic [32*(1<<LINE_BITS)-1:0]       wr_line,
  input  logic                               flush_clr
);

  localparam int SETS       = 1 << SET_BITS;
  localparam int LINE_WORDS = line_words(LINE_BITS);

  logic [31:0]      data_q [SETS][LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;

  // Valid bits: a flush clears every set and takes priority over an install.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
    end else if (flush_clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and line data are written together when a refilled line is installed.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_index] <= wr_tag;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_q[wr_index][w] <= wr_line[32*w +: 32];
      end
    end
  end

  assign lk_valid = valid_q[lk_index];
  assign lk_hit   = lk_valid && (tag_q[lk_index] == lk_tag);
  assign lk_word  = data_q[lk_index][lk_offset];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache (1 or 2 ways, per-set LRU).
// Hits answer one cycle after acceptance; misses refill a whole line through
// a request/beat handshake and answer one cycle after the last beat.
// Optional build macro ICACHE_PERF_EN adds perf_hit_cnt / perf_miss_cnt.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | ready for a fetch (once out of reset and not flushing)
// ST_LOOKUP   | tag compare on the latched address; hit answers here
// ST_MISS_REQ | line refill request held until the controller accepts it
// ST_REFILL   | collecting beats; after a flush the beats are discarded
// ST_RESP     | returning the captured word from a completed refill
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int SET_BITS  = DEF_SET_BITS,
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int WAYS      = DEF_WAYS
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_inst,
  input  logic              flush_in,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_data_valid,
  input  logic [31:0]       mem_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       perf_hit_cnt,
  output logic [31:0]       perf_miss_cnt
`endif
);

  localparam int SETS       = 1 << SET_BITS;
  localparam int LINE_WORDS = line_words(LINE_BITS);
  localparam int TAG_W      = tag_width(ADDR_W, SET_BITS, LINE_BITS);
  localparam int IDX_LO     = LINE_BITS + 2;
  localparam int TAG_LO     = SET_BITS + LINE_BITS + 2;

  state_e                  state_q, state_d;
  logic                    init_q;
  logic [ADDR_W-1:2]       req_addr_q;
  logic [LINE_BITS-1:0]    beat_q;
  logic                    drop_q;
  logic [32*LINE_WORDS-1:0] line_buf_q;
  logic [32*LINE_WORDS-1:0] fill_line;
  logic [31:0]             resp_word_q;
  logic [SETS-1:0]         lru_q;

  logic [SET_BITS-1:0]     req_index;
  logic [LINE_BITS-1:0]    req_offset;
  logic [TAG_W-1:0]        req_tag;

  logic [WAYS-1:0]         way_hit;
  logic [WAYS-1:0]         way_valid;
  logic [WAYS-1:0]         way_wr;
  logic [31:0]             way_word [WAYS];

  logic                    hit_any;
  logic [31:0]             hit_word;
  logic                    victim;

  logic                    accept;
  logic                    lookup_hit;
  logic                    lookup_miss;
  logic                    beat_take;
  logic                    last_beat;
  logic                    install;
  logic                    flush_clr;

  // Byte-lane bits of the fetch address carry no information for a word cache.
  logic                    unused_addr_lsb;
  assign unused_addr_lsb = ^if_req_addr[1:0];

  assign req_offset   = req_addr_q[IDX_LO-1:2];
  assign req_index    = req_addr_q[TAG_LO-1:IDX_LO];
  assign req_tag      = req_addr_q[ADDR_W-1:TAG_LO];
  assign mem_req_addr = {req_addr_q[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}};

  // Every event is qualified by rdy_in so a global stall freezes all updates.
  assign accept      = rdy_in && if_req_valid && if_req_ready;
  assign lookup_hit  = rdy_in && (state_q == ST_LOOKUP) && !flush_in && hit_any;
  assign lookup_miss = rdy_in && (state_q == ST_LOOKUP) && !flush_in && !hit_any;
  assign beat_take   = rdy_in && (state_q == ST_REFILL) && mem_data_valid;
  assign last_beat   = beat_take && (&beat_q);
  assign install     = last_beat && !drop_q && !flush_in;
  assign flush_clr   = rdy_in && flush_in;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign way_wr[g] = install && (int'(victim) == g);

    icache_way #(
      .SET_BITS  (SET_BITS),
      .LINE_BITS (LINE_BITS),
      .TAG_W     (TAG_W)
    ) u_way (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .lk_index  (req_index),
      .lk_offset (req_offset),
      .lk_tag    (req_tag),
      .lk_valid  (way_valid[g]),
      .lk_hit    (way_hit[g]),
      .lk_word   (way_word[g]),
      .wr_en     (way_wr[g]),
      .wr_index  (req_index),
      .wr_tag    (req_tag),
      .wr_line   (fill_line),
      .flush_clr (flush_clr)
    );
  end

  // Merge the per-way compare results; at most one way can hit.
  always_comb begin
    hit_any  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_any  = 1'b1;
        hit_word = hit_word | way_word[w];
      end
    end
  end

  // Victim: an empty way first (way 0 before way 1), otherwise the LRU way.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!way_valid[0]) begin
        victim = 1'b0;
      end else if (!way_valid[WAYS-1]) begin
        victim = 1'b1;
      end else begin
        victim = lru_q[req_index];
      end
    end
  end

  // The final beat goes straight into the installed line, bypassing the buffer.
  always_comb begin
    fill_line = line_buf_q;
    fill_line[int'(beat_q)*32 +: 32] = mem_data;
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) state_d = ST_LOOKUP;
        end
        ST_LOOKUP: begin
          if (flush_in || hit_any) state_d = ST_IDLE;
          else                     state_d = ST_MISS_REQ;
        end
        ST_MISS_REQ: begin
          if (flush_in)           state_d = ST_IDLE;
          else if (mem_req_ready) state_d = ST_REFILL;
        end
        ST_REFILL: begin
          if (last_beat) state_d = install ? ST_RESP : ST_IDLE;
        end
        ST_RESP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode; a flush in the same cycle suppresses any response or request.
  always_comb begin
    if_req_ready  = init_q && rdy_in && (state_q == ST_IDLE) && !flush_in;
    if_resp_valid = 1'b0;
    if_resp_inst  = '0;
    mem_req_valid = 1'b0;
    case (state_q)
      ST_LOOKUP: begin
        if (hit_any && !flush_in) begin
          if_resp_valid = 1'b1;
          if_resp_inst  = hit_word;
        end
      end
      ST_MISS_REQ: begin
        mem_req_valid = !flush_in;
      end
      ST_RESP: begin
        if (!flush_in) begin
          if_resp_valid = 1'b1;
          if_resp_inst  = resp_word_q;
        end
      end
      default: begin
      end
    endcase
  end

  // Request address latch, beat counter, discard flag, line buffer and captured word.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      init_q      <= 1'b0;
      req_addr_q  <= '0;
      beat_q      <= '0;
      drop_q      <= 1'b0;
      line_buf_q  <= '0;
      resp_word_q <= '0;
    end else if (rdy_in) begin
      init_q <= 1'b1;
      if (accept) begin
        req_addr_q <= if_req_addr[ADDR_W-1:2];
      end
      if ((state_q == ST_MISS_REQ) && mem_req_ready && !flush_in) begin
        beat_q <= '0;
        drop_q <= 1'b0;
      end
      if ((state_q == ST_REFILL) && flush_in) begin
        drop_q <= 1'b1;
      end
      if (beat_take) begin
        beat_q <= beat_q + 1'b1;
        line_buf_q[int'(beat_q)*32 +: 32] <= mem_data;
        if (beat_q == req_offset) begin
          resp_word_q <= mem_data;
        end
      end
    end
  end

  // LRU bit names the way to replace next: the way not just used.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lru_q <= '0;
    end else if (lookup_hit) begin
      lru_q[req_index] <= way_hit[0];
    end else if (install) begin
      lru_q[req_index] <= ~victim;
    end
  end

`ifdef ICACHE_PERF_EN
  // Lookup outcome counters; free-running, survive flush, cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (lookup_hit)  perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      if (lookup_miss) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Directed plus randomized bench for icache_sa (default geometry, 2 ways).
// Expected hit/miss outcomes come from a per-set recency queue of tags.
module tb_icache_sa;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        flush_in;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_data_valid;
  logic [31:0] mem_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference cache contents: per set, a queue of tags with most recent first.
  int m_q [64][$];

  always #5 clk_in = ~clk_in;

  icache_sa dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .if_req_valid   (if_req_valid),
    .if_req_addr    (if_req_addr),
    .if_req_ready   (if_req_ready),
    .if_resp_valid  (if_resp_valid),
    .if_resp_inst   (if_resp_inst),
    .flush_in       (flush_in),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit_cnt   (perf_hit_cnt),
    .perf_miss_cnt  (perf_miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Backing memory contents seen by the refill port.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] line = a & 32'hFFFF_FFF0;
    logic [31:0] w    = 32'(a[3:2]);
    if (line == 32'h0000_0100) return 32'hA0 + w;
    return (line * 32'h9E37_79B1) ^ (w * 32'h0101_0101) ^ 32'h5A00_0000;
  endfunction

  function automatic int m_set(input logic [31:0] a);
    return int'(a[9:4]);
  endfunction

  function automatic int m_tag(input logic [31:0] a);
    return int'(a >> 10);
  endfunction

  function automatic bit m_probe(input logic [31:0] a);
    int s = m_set(a);
    for (int i = 0; i < m_q[s].size(); i++) begin
      if (m_q[s][i] == m_tag(a)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void m_touch(input logic [31:0] a);
    int s = m_set(a);
    for (int i = 0; i < m_q[s].size(); i++) begin
      if (m_q[s][i] == m_tag(a)) begin
        m_q[s].delete(i);
        break;
      end
    end
    m_q[s].push_front(m_tag(a));
  endfunction

  function automatic void m_fill(input logic [31:0] a);
    int s = m_set(a);
    m_q[s].push_front(m_tag(a));
    if (m_q[s].size() > 2) void'(m_q[s].pop_back());
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 64; s++) m_q[s].delete();
  endfunction

  // Present a request, wait (bounded) for ready, and return in the LOOKUP cycle.
  task automatic issue(input logic [31:0] a);
    int n = 0;
    if_req_addr  = a | 32'($urandom_range(0, 3));
    if_req_valid = 1'b1;
    while (!if_req_ready && n < 30) begin
      @(negedge clk_in);
      n++;
    end
    chk("req_ready", 32'(if_req_ready), 32'd1);
    @(posedge clk_in);
    #1;
    if_req_valid = 1'b0;
    @(negedge clk_in);
  endtask

  // Act as the memory controller from the MISS_REQ cycle to the response cycle.
  task automatic serve(input logic [31:0] a, input int grant_delay, input bit gaps);
    logic [31:0] line = a & 32'hFFFF_FFF0;
    chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("mem_req_addr", mem_req_addr, line);
    for (int k = 0; k < grant_delay; k++) begin
      @(negedge clk_in);
      chk("mem_req_hold", 32'(mem_req_valid), 32'd1);
    end
    mem_req_ready = 1'b1;
    @(posedge clk_in);
    #1;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk_in);
          #1;
        end
      end
      mem_data_valid = 1'b1;
      mem_data       = mem_word(line + 32'(4 * i));
      @(posedge clk_in);
      #1;
      mem_data_valid = 1'b0;
    end
    @(negedge clk_in);
    chk("miss_resp_valid", 32'(if_resp_valid), 32'd1);
    chk("miss_resp_inst", if_resp_inst, mem_word(a & 32'hFFFF_FFFC));
  endtask

  task automatic fetch(input logic [31:0] a, input bit gaps);
    bit exp_hit = m_probe(a);
    issue(a);
    chk("hit_flag", 32'(if_resp_valid), 32'(exp_hit));
    if (exp_hit) begin
      chk("hit_inst", if_resp_inst, mem_word(a));
      m_touch(a);
    end else begin
      chk("no_req_in_lookup", 32'(mem_req_valid), 32'd0);
      @(negedge clk_in);
      serve(a, gaps ? int'($urandom_range(0, 2)) : 0, gaps);
      m_fill(a);
    end
  endtask

  initial begin
    rst_n_in       = 1'b0;
    rdy_in         = 1'b1;
    if_req_valid   = 1'b0;
    if_req_addr    = '0;
    flush_in       = 1'b0;
    mem_req_ready  = 1'b0;
    mem_data_valid = 1'b0;
    mem_data       = '0;
    m_clear();

    repeat (3) @(negedge clk_in);
    chk("rst_req_ready", 32'(if_req_ready), 32'd0);
    chk("rst_resp_valid", 32'(if_resp_valid), 32'd0);
    chk("rst_resp_inst", if_resp_inst, 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("rst_perf_hit", perf_hit_cnt, 32'd0);
    chk("rst_perf_miss", perf_miss_cnt, 32'd0);
`endif
    rst_n_in = 1'b1;
    #1;
    chk("ready_before_clock", 32'(if_req_ready), 32'd0);
    @(negedge clk_in);
    chk("ready_after_clock", 32'(if_req_ready), 32'd1);

    // Cold miss then a hit on another word of the same line.
    fetch(32'h0000_0104, 1'b0);
    fetch(32'h0000_0108, 1'b0);

    // Same-set conflict: touching 0x100 makes 0x1100 the eviction victim.
    fetch(32'h0000_1100, 1'b1);
    fetch(32'h0000_0100, 1'b0);
    fetch(32'h0000_2100, 1'b1);
    fetch(32'h0000_0100, 1'b0);
    fetch(32'h0000_1100, 1'b1);

    // Random mix over two sets and three tags each.
    for (int r = 0; r < 30; r++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 2)) << 12) | (32'h100 + 32'h40 * 32'($urandom_range(0, 1)))
          | (32'($urandom_range(0, 3)) << 2);
      fetch(a, 1'b1);
    end

    // Flush while idle.
    @(negedge clk_in);
    flush_in = 1'b1;
    #1;
    chk("ready_during_flush", 32'(if_req_ready), 32'd0);
    @(posedge clk_in);
    #1;
    flush_in = 1'b0;
    m_clear();

    // Flush during refill after beat 1: drain, no response, no install.
    issue(32'h0000_0100);
    chk("flush_test_miss", 32'(if_resp_valid), 32'd0);
    @(negedge clk_in);
    chk("flush_test_req", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(posedge clk_in);
    #1;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_data_valid = 1'b1;
      mem_data       = mem_word(32'h100 + 32'(4 * i));
      @(posedge clk_in);
      #1;
    end
    mem_data_valid = 1'b0;
    flush_in       = 1'b1;
    @(posedge clk_in);
    #1;
    flush_in = 1'b0;
    for (int i = 2; i < 4; i++) begin
      mem_data_valid = 1'b1;
      mem_data       = mem_word(32'h100 + 32'(4 * i));
      @(negedge clk_in);
      chk("drain_no_resp", 32'(if_resp_valid), 32'd0);
      @(posedge clk_in);
      #1;
    end
    mem_data_valid = 1'b0;
    @(negedge clk_in);
    chk("drain_end_no_resp", 32'(if_resp_valid), 32'd0);
    chk("drain_end_ready", 32'(if_req_ready), 32'd1);
    fetch(32'h0000_0100, 1'b0);

    // Global stall in MISS_REQ with the controller already ready.
    @(negedge clk_in);
    issue(32'h0000_3300);
    chk("stall_test_miss", 32'(if_resp_valid), 32'd0);
    @(negedge clk_in);
    mem_req_ready = 1'b1;
    rdy_in        = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      chk("stall_req_hold", 32'(mem_req_valid), 32'd1);
    end
    rdy_in        = 1'b1;
    mem_req_ready = 1'b0;
    serve(32'h0000_3300, 0, 1'b0);
    m_fill(32'h0000_3300);
    fetch(32'h0000_3304, 1'b0);

    // Reset in the middle of a refill.
    @(negedge clk_in);
    issue(32'h0000_0500);
    chk("rst_test_miss", 32'(if_resp_valid), 32'd0);
    @(negedge clk_in);
    mem_req_ready = 1'b1;
    @(posedge clk_in);
    #1;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_data_valid = 1'b1;
      mem_data       = mem_word(32'h500 + 32'(4 * i));
      @(posedge clk_in);
      #1;
    end
    mem_data = mem_word(32'h508);
    rst_n_in = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(if_req_ready), 32'd0);
    chk("midrst_resp_valid", 32'(if_resp_valid), 32'd0);
    chk("midrst_resp_inst", if_resp_inst, 32'd0);
    chk("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_mem_req_addr", mem_req_addr, 32'd0);
    @(negedge clk_in);
    mem_data = mem_word(32'h50C);
    @(negedge clk_in);
    rst_n_in       = 1'b1;
    mem_data_valid = 1'b0;
    m_clear();

    // After reset: two misses and three hits.
    fetch(32'h0000_0500, 1'b0);
    fetch(32'h0000_0504, 1'b0);
    fetch(32'h0000_0508, 1'b0);
    fetch(32'h0000_0600, 1'b1);
    fetch(32'h0000_0604, 1'b0);
    @(negedge clk_in);
`ifdef ICACHE_PERF_EN
    chk("perf_hit_cnt", perf_hit_cnt, 32'd3);
    chk("perf_miss_cnt", perf_miss_cnt, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache between the instruction fetcher and the memory controller. It serves word fetches with 1-cycle latency on a hit. On a miss it refills a whole multi-word line through a request/beat handshake and returns the requested word when the refill ends. It supports one or two ways with per-set LRU replacement, and a flush input for fence.i and pipeline clear.

## Interface
- ADDR_W, 32, byte address width
- SET_BITS, 6, log2 of set count (64 sets)
- LINE_BITS, 2, log2 of words per line (4 words, 16 bytes)
- WAYS, 2, associativity, legal values 1 or 2
- clk_in  input  1  clock
- rst_n_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global enable; low freezes all state
- if_req_valid  input  1  fetch request
- if_req_addr  input  ADDR_W  fetch byte address; bits [1:0] ignored
- if_req_ready  output  1  request accepted when valid && ready
- if_resp_valid  output  1  one-cycle pulse, instruction valid
- if_resp_inst  output  32  fetched instruction
- flush_in  input  1  invalidate all lines, abort pending fetch
- mem_req_valid  output  1  line refill request
- mem_req_addr  output  ADDR_W  line-aligned refill address
- mem_req_ready  input  1  controller accepts refill request
- mem_data_valid  input  1  refill beat valid
- mem_data  input  32  refill word; beats arrive in ascending word order
- perf_hit_cnt, perf_miss_cnt  output  32 each  only with ICACHE_PERF_EN

## Operation
- Address split: offset = [LINE_BITS+1:2]; index = [SET_BITS+LINE_BITS+1:LINE_BITS+2]; tag = remaining upper bits.
- Storage per way: data[sets][words], tag[sets], valid bit vector. With WAYS=2, one LRU bit per set.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE: if_req_ready = !flush_in. Accepted requests latch the address and move to LOOKUP.
- LOOKUP: compare tags on all valid ways of the set.
  - Hit: if_resp_valid=1 with the word; LRU points at the other way; go to IDLE.
  - Miss: go to MISS_REQ.
- MISS_REQ: mem_req_valid=1 with the line address. Hold until mem_req_ready, then go to REFILL with the beat counter at 0.
- REFILL: each mem_data_valid writes a word into a line buffer and increments the counter.
  - The word at the requested offset is captured.
  - On beat LINE_WORDS-1, the line, tag and valid bit are written to the victim way and LRU is updated; go to RESP.
- RESP: if_resp_valid=1 with the captured word; go to IDLE.
- Victim: first invalid way (way 0 first), else the LRU way. WAYS=1 always uses way 0.
- flush_in clears every valid bit in the next cycle and cancels any response not yet driven:
  - IDLE/LOOKUP/RESP: go to IDLE, no response.
  - MISS_REQ before acceptance: drop mem_req_valid, go to IDLE.
  - REFILL: remaining beats are drained into a discard counter, the line is not installed, no response, then IDLE.
- rdy_in low: no state, counter or array update. Outputs hold. The memory controller sends no beats while rdy_in is low.

## Timing
- Reset values: if_req_ready=0, if_resp_valid=0, if_resp_inst=0, mem_req_valid=0, mem_req_addr=0, perf counters 0. FSM is in IDLE, all valid and LRU bits are 0. Data and tag arrays are not reset.
- if_req_ready rises on the first clock after reset release.
- Hit: request accepted at cycle N, response at N+1.
- Miss: mem_req_valid from N+2. The response comes 1 cycle after the last beat.
- Back-to-back hits: one request per 2 cycles (IDLE→LOOKUP).
- Reset asserted mid-refill aborts immediately. The line is not installed and in-flight beats are ignored.

## Configuration
- ICACHE_PERF_EN defined: perf_hit_cnt and perf_miss_cnt exist.
  - The hit counter increments once per LOOKUP hit; the miss counter once per LOOKUP miss.
  - Both wrap at 2^32 and are not cleared by flush.
- ICACHE_PERF_EN undefined: the ports and counters are absent.

## Structure
- Shared package: FSM state encoding, the LINE_WORDS/TAG_W derivation helpers, and the default parameter constants.
- Sub-module icache_way: tag/data/valid storage for one way with a lookup compare port, a line write port and a flush-clear. It is instantiated WAYS times.

## Test plan
- Cold miss at 0x0000_0104:
  - mem_req_addr=0x100; beats 0xA0,0xA1,0xA2,0xA3; response 0xA1 one cycle after the last beat.
  - A repeat fetch of 0x108 then hits with 0xA2 at N+1.
- WAYS=2 conflict:
  - Fill 0x0100, then 0x1100 (same set), touch 0x0100, then fetch 0x2100.
  - 0x1100's way is evicted. Re-fetching 0x0100 hits; re-fetching 0x1100 misses.
- Flush during REFILL after beat 1:
  - The remaining beats are drained, no if_resp_valid is produced, and the line is not installed.
  - The next fetch to 0x100 misses.
- rdy_in low for 5 cycles mid-MISS_REQ while mem_req_ready=1: no acceptance occurs until rdy_in returns; the sequence then completes normally.
- rst_n_in pulsed low during REFILL: all outputs 0 immediately, and a subsequent fetch of the same line misses.
- ICACHE_PERF_EN: three hits and two misses give perf_hit_cnt=3 and perf_miss_cnt=2.
